// File: rtl/dmem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_ctrl_pkg
//  Description : Shared control encodings for the data-memory controller:
//                access-size codes, FSM state encoding, alignment helper.
//  Revision    : 1.0  initial release
// ============================================================================
package dmem_ctrl_pkg;

    // Access size codes as driven on cpu_size; 2'b11 is handled as a word
    localparam logic [1:0] c_sz_byte = 2'b00;
    localparam logic [1:0] c_sz_half = 2'b01;
    localparam logic [1:0] c_sz_word = 2'b10;

    // Controller FSM states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Natural alignment: halves on even bytes, words on 4-byte boundaries
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic ok;
        case (size)
            c_sz_byte: ok = 1'b1;
            c_sz_half: ok = ~addr_lo[0];
            default:   ok = (addr_lo == 2'b00);
        endcase
        return ok;
    endfunction

endpackage : dmem_ctrl_pkg
`default_nettype wire

// File: rtl/ldst_align.sv
`default_nettype none
// ============================================================================
//  Module      : ldst_align
//  Description : Byte-lane steering for loads and stores. Builds byte
//                enables and lane-replicated store data, and selects plus
//                sign/zero-extends the addressed lane of a loaded word.
//  Revision    : 1.0  initial release
// ============================================================================
module ldst_align
    import dmem_ctrl_pkg::*;
(
    input  logic [1:0]  i_st_size,
    input  logic [1:0]  i_st_addr_lo,
    input  logic [31:0] i_st_wdata,
    output logic [3:0]  o_st_be,
    output logic [31:0] o_st_wdata,
    input  logic [1:0]  i_ld_size,
    input  logic [1:0]  i_ld_addr_lo,
    input  logic        i_ld_unsigned,
    input  logic [31:0] i_ld_word,
    output logic [31:0] o_ld_data
);

    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;

    // Store side: enables for the addressed lanes, data copied into every lane
    always_comb begin
        o_st_be    = 4'b1111;
        o_st_wdata = i_st_wdata;
        case (i_st_size)
            c_sz_byte: begin
                o_st_be    = 4'b0001 << i_st_addr_lo;
                o_st_wdata = {4{i_st_wdata[7:0]}};
            end
            c_sz_half: begin
                o_st_be    = i_st_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_st_wdata = {2{i_st_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Load side: pick the addressed lane, then extend to 32 bits
    always_comb begin
        w_ld_byte = i_ld_word[7:0];
        case (i_ld_addr_lo)
            2'd1:    w_ld_byte = i_ld_word[15:8];
            2'd2:    w_ld_byte = i_ld_word[23:16];
            2'd3:    w_ld_byte = i_ld_word[31:24];
            default: w_ld_byte = i_ld_word[7:0];
        endcase
        w_ld_half = i_ld_addr_lo[1] ? i_ld_word[31:16] : i_ld_word[15:0];
        case (i_ld_size)
            c_sz_byte: o_ld_data = {{24{~i_ld_unsigned & w_ld_byte[7]}}, w_ld_byte};
            c_sz_half: o_ld_data = {{16{~i_ld_unsigned & w_ld_half[15]}}, w_ld_half};
            default:   o_ld_data = i_ld_word;
        endcase
    end

endmodule : ldst_align
`default_nettype wire

// File: rtl/dmem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_ctrl
//  Description : CPU load/store to word-memory bridge. Aligns accesses,
//                stalls the CPU while the memory request is outstanding,
//                reports misalignment and ack timeout through cpu_err.
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [1:0]  cpu_size,
    input  logic        cpu_unsigned,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        cpu_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    // Counter only needs to reach TIMEOUT-1: the last WAIT cycle is decided on that value
    localparam int                 c_cnt_w    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 w_aligned;
    logic [c_cnt_w-1:0]   r_wait_cnt;
    logic [31:0]          r_mem_addr;
    logic                 r_mem_we;
    logic [3:0]           r_mem_be;
    logic [31:0]          r_mem_wdata;
    logic [1:0]           r_size;
    logic                 r_unsigned;
    logic [1:0]           r_addr_lo;
    logic [31:0]          r_rdata;
    logic                 r_err;
    logic [3:0]           w_st_be;
    logic [31:0]          w_st_wdata;
    logic [31:0]          w_ld_data;

    ldst_align u_ldst_align (
        .i_st_size     (cpu_size),
        .i_st_addr_lo  (cpu_addr[1:0]),
        .i_st_wdata    (cpu_wdata),
        .o_st_be       (w_st_be),
        .o_st_wdata    (w_st_wdata),
        .i_ld_size     (r_size),
        .i_ld_addr_lo  (r_addr_lo),
        .i_ld_unsigned (r_unsigned),
        .i_ld_word     (mem_rdata),
        .o_ld_data     (w_ld_data)
    );

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic; a misaligned request skips WAIT and reports at once
    always_comb begin
        w_state_nxt = r_state;
        w_aligned   = is_aligned(cpu_size, cpu_addr[1:0]);
        case (r_state)
            S_IDLE:  if (cpu_req) w_state_nxt = w_aligned ? S_WAIT : S_DONE;
            S_WAIT:  if (mem_ack || (r_wait_cnt == c_cnt_last)) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Request capture, wait counting and response registration
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wait_cnt  <= '0;
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= '0;
            r_mem_wdata <= '0;
            r_size      <= '0;
            r_unsigned  <= 1'b0;
            r_addr_lo   <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cpu_req) begin
                        if (w_aligned) begin
                            r_mem_addr  <= {cpu_addr[31:2], 2'b00};
                            r_mem_we    <= cpu_we;
                            r_mem_be    <= w_st_be;
                            r_mem_wdata <= w_st_wdata;
                            r_size      <= cpu_size;
                            r_unsigned  <= cpu_unsigned;
                            r_addr_lo   <= cpu_addr[1:0];
                            r_wait_cnt  <= '0;
                        end else begin
                            r_rdata <= '0;
                            r_err   <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (mem_ack) begin
                        r_rdata <= r_mem_we ? 32'd0 : w_ld_data;
                        r_err   <= 1'b0;
                    end else if (r_wait_cnt == c_cnt_last) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + c_cnt_one;
                    end
                end
                default: ;
            endcase
        end
    end

    // Response is visible only during the single DONE cycle
    assign cpu_rdata = (r_state == S_DONE) ? r_rdata : 32'd0;
    assign cpu_err   = (r_state == S_DONE) & r_err;
    assign cpu_stall = ((r_state == S_IDLE) & cpu_req) | (r_state == S_WAIT);

    assign mem_req   = (r_state == S_WAIT);
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_be    = r_mem_be;
    assign mem_wdata = r_mem_wdata;

endmodule : dmem_ctrl
`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_ctrl
//  Description : Directed self-checking bench for dmem_ctrl (TIMEOUT=4).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dmem_ctrl;

    logic        clk;
    logic        reset;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [1:0]  cpu_size;
    logic        cpu_unsigned;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        cpu_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_checks;
    int n_fail;

    // Observations gathered by do_access
    logic [31:0] a_rdata;
    logic        a_err;
    int          a_stalls;
    int          a_reqs;
    logic [31:0] a_addr;
    logic [31:0] a_wdata;
    logic [3:0]  a_be;
    logic        a_we;
    logic        a_done;

    dmem_ctrl #(.TIMEOUT(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_req      (cpu_req),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_size     (cpu_size),
        .cpu_unsigned (cpu_unsigned),
        .cpu_rdata    (cpu_rdata),
        .cpu_stall    (cpu_stall),
        .cpu_err      (cpu_err),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_be       (mem_be),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one access and follow it to its DONE cycle (bounded).
    // ack_at = index of the WAIT cycle in which mem_ack is pulsed; -1 = never.
    task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [1:0] size, input logic uns, input int ack_at,
                             input logic [31:0] rd);
        int wait_n;
        wait_n   = 0;
        a_done   = 1'b0;
        a_rdata  = 'x;
        a_err    = 1'bx;
        a_addr   = 'x;
        a_wdata  = 'x;
        a_be     = 'x;
        a_we     = 1'bx;
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        cpu_size = size; cpu_unsigned = uns;
        #1;
        a_stalls = int'(cpu_stall);
        a_reqs   = int'(mem_req);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            cpu_req = 1'b0;
            mem_ack = 1'b0;
            #1;
            if (mem_req) begin
                a_addr  = mem_addr;
                a_wdata = mem_wdata;
                a_be    = mem_be;
                a_we    = mem_we;
                if (wait_n == ack_at) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rd;
                end
                wait_n++;
                a_reqs++;
            end
            if (cpu_stall) a_stalls++;
            else begin
                a_done  = 1'b1;
                a_rdata = cpu_rdata;
                a_err   = cpu_err;
                break;
            end
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        cpu_size = 2'b00; cpu_unsigned = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #2;
        n_checks++;
        if ({mem_req, mem_we, mem_be, cpu_err, cpu_stall} !== 8'h00) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 00", {mem_req, mem_we, mem_be, cpu_err, cpu_stall});
        end
        n_checks++;
        if ({mem_addr, mem_wdata, cpu_rdata} !== 96'd0) begin
            n_fail++; $display("FAIL reset_data: addr %h wdata %h rdata %h expected all 0", mem_addr, mem_wdata, cpu_rdata);
        end
        reset = 1'b1;
    endtask

    task automatic test_word_load();
        do_access(1'b0, 32'h0000_0100, 32'h0, 2'b10, 1'b0, 1, 32'h8765_4321);
        n_checks++;
        if (a_done !== 1'b1) begin n_fail++; $display("FAIL lw_done: got %b expected 1", a_done); end
        n_checks++;
        if (a_be !== 4'b1111 || a_addr !== 32'h100 || a_we !== 1'b0) begin
            n_fail++; $display("FAIL lw_mem: be %b addr %h we %b expected 1111 00000100 0", a_be, a_addr, a_we);
        end
        n_checks++;
        if (a_rdata !== 32'h8765_4321 || a_err !== 1'b0) begin
            n_fail++; $display("FAIL lw_rdata: got %h err %b expected 87654321 err 0", a_rdata, a_err);
        end
        n_checks++;
        if (a_stalls != 3 || a_reqs != 2) begin
            n_fail++; $display("FAIL lw_timing: stall %0d req %0d cycles expected 3 and 2", a_stalls, a_reqs);
        end
        // Result must not linger past DONE
        @(posedge clk); #2;
        n_checks++;
        if (cpu_rdata !== 32'd0 || cpu_stall !== 1'b0) begin
            n_fail++; $display("FAIL lw_after_done: rdata %h stall %b expected 0 0", cpu_rdata, cpu_stall);
        end
    endtask

    task automatic test_byte_half_loads();
        do_access(1'b0, 32'h0000_0103, 32'h0, 2'b00, 1'b0, 0, 32'h80FF_FFFF);
        n_checks++;
        if (a_be !== 4'b1000 || a_addr !== 32'h100 || a_rdata !== 32'hFFFF_FF80) begin
            n_fail++; $display("FAIL lb: be %b addr %h rdata %h expected 1000 00000100 ffffff80", a_be, a_addr, a_rdata);
        end
        do_access(1'b0, 32'h0000_0103, 32'h0, 2'b00, 1'b1, 0, 32'h80FF_FFFF);
        n_checks++;
        if (a_rdata !== 32'h0000_0080) begin
            n_fail++; $display("FAIL lbu: got %h expected 00000080", a_rdata);
        end
        do_access(1'b0, 32'h0000_0002, 32'h0, 2'b01, 1'b0, 2, 32'h8001_7FFF);
        n_checks++;
        if (a_be !== 4'b1100 || a_rdata !== 32'hFFFF_8001 || a_stalls != 4) begin
            n_fail++; $display("FAIL lh_hi: be %b rdata %h stalls %0d expected 1100 ffff8001 4", a_be, a_rdata, a_stalls);
        end
        do_access(1'b0, 32'h0000_0000, 32'h0, 2'b01, 1'b1, 0, 32'h8001_F00D);
        n_checks++;
        if (a_be !== 4'b0011 || a_rdata !== 32'h0000_F00D) begin
            n_fail++; $display("FAIL lhu_lo: be %b rdata %h expected 0011 0000f00d", a_be, a_rdata);
        end
        // Size code 11 behaves as a word
        do_access(1'b0, 32'h0000_0008, 32'h0, 2'b11, 1'b1, 0, 32'hC0DE_0001);
        n_checks++;
        if (a_be !== 4'b1111 || a_rdata !== 32'hC0DE_0001 || a_addr !== 32'h8) begin
            n_fail++; $display("FAIL size11: be %b rdata %h addr %h expected 1111 c0de0001 00000008", a_be, a_rdata, a_addr);
        end
    endtask

    task automatic test_stores();
        do_access(1'b1, 32'h0000_0202, 32'h1234_ABCD, 2'b01, 1'b0, 0, 32'hFFFF_FFFF);
        n_checks++;
        if (a_addr !== 32'h200 || a_be !== 4'b1100 || a_wdata !== 32'hABCD_ABCD || a_we !== 1'b1) begin
            n_fail++; $display("FAIL sh: addr %h be %b wdata %h we %b expected 00000200 1100 abcdabcd 1", a_addr, a_be, a_wdata, a_we);
        end
        n_checks++;
        if (a_rdata !== 32'd0 || a_err !== 1'b0) begin
            n_fail++; $display("FAIL sh_resp: rdata %h err %b expected 0 0", a_rdata, a_err);
        end
        do_access(1'b1, 32'h0000_0011, 32'h0000_005A, 2'b00, 1'b0, 0, 32'h0);
        n_checks++;
        if (a_addr !== 32'h10 || a_be !== 4'b0010 || a_wdata !== 32'h5A5A_5A5A) begin
            n_fail++; $display("FAIL sb: addr %h be %b wdata %h expected 00000010 0010 5a5a5a5a", a_addr, a_be, a_wdata);
        end
        do_access(1'b1, 32'h0000_0020, 32'hCAFE_F00D, 2'b10, 1'b0, 0, 32'h0);
        n_checks++;
        if (a_be !== 4'b1111 || a_wdata !== 32'hCAFE_F00D) begin
            n_fail++; $display("FAIL sw: be %b wdata %h expected 1111 cafef00d", a_be, a_wdata);
        end
    endtask

    task automatic test_misaligned();
        do_access(1'b0, 32'h0000_0105, 32'h0, 2'b10, 1'b0, 0, 32'h1111_1111);
        n_checks++;
        if (a_done !== 1'b1 || a_reqs != 0 || a_stalls != 1) begin
            n_fail++; $display("FAIL lw_misaligned_timing: done %b req %0d stall %0d expected 1 0 1", a_done, a_reqs, a_stalls);
        end
        n_checks++;
        if (a_err !== 1'b1 || a_rdata !== 32'd0) begin
            n_fail++; $display("FAIL lw_misaligned_resp: err %b rdata %h expected 1 0", a_err, a_rdata);
        end
        do_access(1'b0, 32'h0000_0101, 32'h0, 2'b01, 1'b0, 0, 32'h1111_1111);
        n_checks++;
        if (a_err !== 1'b1 || a_reqs != 0) begin
            n_fail++; $display("FAIL lh_misaligned: err %b req %0d expected 1 0", a_err, a_reqs);
        end
    endtask

    task automatic test_timeout();
        do_access(1'b0, 32'h0000_0040, 32'h0, 2'b10, 1'b0, -1, 32'h0);
        n_checks++;
        if (a_done !== 1'b1 || a_reqs != 4 || a_stalls != 5) begin
            n_fail++; $display("FAIL timeout_timing: done %b req %0d stall %0d expected 1 4 5", a_done, a_reqs, a_stalls);
        end
        n_checks++;
        if (a_err !== 1'b1 || a_rdata !== 32'd0) begin
            n_fail++; $display("FAIL timeout_resp: err %b rdata %h expected 1 0", a_err, a_rdata);
        end
        // Next cycle must be IDLE: a request raises stall there (it would not in DONE)
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_addr = 32'h0000_0003; cpu_size = 2'b10; cpu_we = 1'b0;
        #1;
        n_checks++;
        if (cpu_stall !== 1'b1 || cpu_err !== 1'b0 || mem_req !== 1'b0) begin
            n_fail++; $display("FAIL timeout_idle: stall %b err %b req %b expected 1 0 0", cpu_stall, cpu_err, mem_req);
        end
        @(posedge clk); #1;
        cpu_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_wait();
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_0010; cpu_wdata = 32'hDEAD_BEEF; cpu_size = 2'b10;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        #1;
        n_checks++;
        if (mem_req !== 1'b1 || mem_wdata !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL rstwait_pre: req %b wdata %h expected 1 deadbeef", mem_req, mem_wdata);
        end
        #1 reset = 1'b0;
        #1;
        n_checks++;
        if ({mem_req, mem_we, mem_be, cpu_err, cpu_stall} !== 8'h00 || {mem_addr, mem_wdata, cpu_rdata} !== 96'd0) begin
            n_fail++; $display("FAIL rstwait_async: ctrl %b addr %h wdata %h rdata %h expected all 0",
                               {mem_req, mem_we, mem_be, cpu_err, cpu_stall}, mem_addr, mem_wdata, cpu_rdata);
        end
        @(posedge clk); #3;
        reset = 1'b1;
        // Late ack after release must be ignored
        @(posedge clk); #1;
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (cpu_stall !== 1'b0 || cpu_err !== 1'b0 || mem_req !== 1'b0 || cpu_rdata !== 32'd0) begin
                n_fail++; $display("FAIL rstwait_late_ack[%0d]: stall %b err %b req %b rdata %h expected 0 0 0 0",
                                   i, cpu_stall, cpu_err, mem_req, cpu_rdata);
            end
            @(posedge clk); #1;
        end
        // Controller resumes normally from IDLE
        do_access(1'b0, 32'h0000_0104, 32'h0, 2'b10, 1'b0, 0, 32'h0BAD_CAFE);
        n_checks++;
        if (a_done !== 1'b1 || a_rdata !== 32'h0BAD_CAFE || a_stalls != 2) begin
            n_fail++; $display("FAIL rstwait_resume: done %b rdata %h stall %0d expected 1 0badcafe 2", a_done, a_rdata, a_stalls);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_word_load();
        test_byte_half_loads();
        test_stores();
        test_misaligned();
        test_timeout();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global bound on simulation time
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_dmem_ctrl
`default_nettype wire

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: maximum cycles to wait for mem_ack before aborting.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port cpu_req, input, 1: CPU load/store valid.
REQ-005 SHALL have port cpu_we, input, 1: 1 = store, 0 = load.
REQ-006 SHALL have port cpu_addr, input, 32: byte address (ALU result).
REQ-007 SHALL have port cpu_wdata, input, 32: store data (rs2 value).
REQ-008 SHALL have port cpu_size, input, 2: 00 byte, 01 half, 10 word; 11 is treated as word.
REQ-009 SHALL have port cpu_unsigned, input, 1: zero-extend load (LBU/LHU).
REQ-010 SHALL have port cpu_rdata, output, 32: extended load data to register write-back.
REQ-011 SHALL have port cpu_stall, output, 1: freezes CPU PC/RF write while high.
REQ-012 SHALL have port cpu_err, output, 1: misaligned or timed-out access.
REQ-013 SHALL have port mem_req, output, 1: memory request.
REQ-014 SHALL have port mem_we, output, 1: memory write.
REQ-015 SHALL have port mem_addr, output, 32: word-aligned address, bits [1:0] = 0.
REQ-016 SHALL have port mem_be, output, 4: byte enables.
REQ-017 SHALL have port mem_wdata, output, 32: lane-replicated store data.
REQ-018 SHALL have port mem_ack, input, 1: memory done, one-cycle pulse.
REQ-019 SHALL have port mem_rdata, input, 32: read word, valid with mem_ack.

Function
REQ-020 SHALL implement a three-state FSM with states IDLE, WAIT and DONE.
REQ-021 In IDLE with cpu_req=1 and an aligned access, SHALL register the address, we, size, unsigned flag, byte enables and lane data, then go to WAIT.
REQ-022 SHALL define alignment as: half requires addr[0]=0; word requires addr[1:0]=00.
REQ-023 In IDLE with cpu_req=1 and a misaligned access, SHALL issue no memory request and go to DONE with the error flag set and the load result 0.
REQ-024 SHALL drive cpu_stall = (IDLE && cpu_req) || WAIT, combinationally; cpu_stall SHALL be 0 in DONE.
REQ-025 In WAIT, SHALL hold mem_req=1 with mem_we, mem_addr, mem_be and mem_wdata stable until mem_ack.
REQ-026 In WAIT, on mem_ack SHALL register the extended load result (0 for stores), clear the error flag and go to DONE.
REQ-027 In WAIT, SHALL increment a wait counter each cycle; when it reaches TIMEOUT without ack, SHALL drop mem_req, set the error flag, set the result to 0 and go to DONE.
REQ-028 In DONE, SHALL present registered cpu_rdata and cpu_err for exactly one cycle, then return to IDLE unconditionally; cpu_req is ignored in DONE.
REQ-029 Load latency: the response SHALL appear in the cycle after mem_ack, giving a minimum of 3 cycles from cpu_req (0-wait memory).
REQ-030 SHALL generate mem_be as follows: byte 0001<<addr[1:0]; half 0011 (addr[1]=0) or 1100 (addr[1]=1); word 1111.
REQ-031 SHALL build mem_wdata as follows: byte replicated to all 4 lanes; half replicated to both halves; word unchanged.
REQ-032 SHALL extract load data from the lane selected by addr[1:0] and sign-extend it, or zero-extend it when cpu_unsigned=1.
REQ-033 SHALL ignore a mem_ack seen outside WAIT.
REQ-034 SHALL clear the wait counter on entry to WAIT.
REQ-035 SHALL drive mem_req=0 in IDLE and DONE.

Reset
REQ-036 On reset=0, SHALL immediately set: state IDLE, mem_req 0, mem_we 0, mem_addr 0, mem_be 0, mem_wdata 0, cpu_rdata 0, cpu_err 0, wait counter 0.
REQ-037 On reset=0 in WAIT, SHALL abort the access at once with no completion reported; after release it SHALL resume from IDLE.

Structure
REQ-038 SHALL place the size encodings (byte/half/word) and FSM state encodings in the shared control-encoding definitions file beside the existing control encodings.
REQ-039 SHALL place lane select and extension/replication logic in one combinational sub-module, ldst_align, instantiated by dmem_ctrl.

Verification
REQ-040 Word load at 0x100, memory returns 0x8765_4321 with ack 2 cycles after mem_req -> mem_be=1111, mem_addr=0x100, cpu_rdata=0x8765_4321 for one DONE cycle, cpu_stall high for 3 cycles.
REQ-041 Signed LB at 0x103, mem_rdata=0x80FF_FFFF -> mem_be=1000, cpu_rdata=0xFFFF_FF80; same access with LBU -> cpu_rdata=0x0000_0080.
REQ-042 SH at 0x202 with cpu_wdata=0x1234_ABCD -> mem_addr=0x200, mem_be=1100, mem_wdata=0xABCD_ABCD, mem_we=1.
REQ-043 LW at 0x105 -> no mem_req, cpu_err=1 and cpu_rdata=0 in the following cycle, stall for 1 cycle.
REQ-044 TIMEOUT=4 with mem_ack never asserted -> mem_req drops after 4 WAIT cycles, cpu_err=1 in DONE, FSM back in IDLE next cycle.
REQ-045 reset pulsed low mid-WAIT -> all outputs 0 asynchronously; a late mem_ack after release produces no response and FSM stays in IDLE.
